i2c_slave: RTL

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_bus_sync.sv | 48 ++++
 rtl/i2c_slave.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target and controller blocks.
// Holds the protocol state encoding and the ACK/NACK bit levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the i_clk domain and flags edges plus START/STOP.
// All registers reset high so an idle bus never looks like a condition.
module i2c_bus_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_sda,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_h;
    logic       sda_h;
    logic       scl;
    logic       sda_rise;
    logic       sda_fall;

    // two-stage synchronizers followed by one history stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_h  <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], i_scl};
            sda_ff <= {sda_ff[0], i_sda};
            scl_h  <= scl_ff[1];
            sda_h  <= sda_ff[1];
        end
    end

    assign scl        = scl_ff[1];
    assign o_sda      = sda_ff[1];
    assign o_scl_rise = scl & ~scl_h;
    assign o_scl_fall = ~scl & scl_h;
    assign sda_rise   = o_sda & ~sda_h;
    assign sda_fall   = ~o_sda & sda_h;
    // SCL must be high in both stages so an SCL edge never aliases
    assign o_start    = sda_fall & scl & scl_h;
    assign o_stop     = sda_rise & scl & scl_h;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address, byte writes to the user, byte reads from it.
// Never stretches SCL; SDA is open-drain driven from a reset register.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic [7:0] o_wr_byte,
    output logic       o_wr_valid,
    input  logic [7:0] i_rd_byte,
    output logic       o_rd_req,
    output logic       o_nack,
    output logic       o_busy
);

    i2c_state_e state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] tx, tx_n;
    logic [7:0] wr_byte_n;
    logic [7:0] byte_in;
    logic       drive, drive_n;
    logic       rw, rw_n;
    logic       wr_valid_n, rd_req_n, nack_n;
    logic       scl_rise, scl_fall, sda_in, start, stop;

    i2c_bus_sync u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (io_sda),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_sda      (sda_in),
        .o_start    (start),
        .o_stop     (stop)
    );

    assign io_sda  = drive ? 1'b0 : 1'bz;
    assign o_busy  = (state != ST_IDLE) && (state != ST_IGNORE);
    assign byte_in = {shreg[6:0], sda_in};

    // state and datapath registers; drive clears asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            shreg      <= 8'h00;
            tx         <= 8'h00;
            drive      <= 1'b0;
            rw         <= 1'b0;
            o_wr_byte  <= 8'h00;
            o_wr_valid <= 1'b0;
            o_rd_req   <= 1'b0;
            o_nack     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            tx         <= tx_n;
            drive      <= drive_n;
            rw         <= rw_n;
            o_wr_byte  <= wr_byte_n;
            o_wr_valid <= wr_valid_n;
            o_rd_req   <= rd_req_n;
            o_nack     <= nack_n;
        end
    end

    // next-state: bus conditions first, then SCL-edge protocol steps
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        tx_n       = tx;
        drive_n    = drive;
        rw_n       = rw;
        wr_byte_n  = o_wr_byte;
        wr_valid_n = 1'b0;
        rd_req_n   = 1'b0;
        nack_n     = 1'b0;
        if (start) begin
            state_n = ST_ADDR;
            cnt_n   = 4'd0;
            drive_n = 1'b0;
        end else if (stop) begin
            state_n = ST_IDLE;
            drive_n = 1'b0;
        end else begin
            case (state)
                ST_ADDR: if (scl_rise) begin
                    shreg_n = byte_in;
                    cnt_n   = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n = 4'd0;
                        if (byte_in[7:1] == SLAVE_ADDR) begin
                            state_n  = ST_ADDR_ACK;
                            rw_n     = byte_in[0];
                            rd_req_n = byte_in[0];
                        end else begin
                            state_n = ST_IGNORE;
                        end
                    end
                end
                // drive flag tells first fall (start ACK) from second (end)
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!drive) begin
                        drive_n = 1'b1;
                    end else if (rw) begin
                        state_n = ST_READ;
                        tx_n    = {i_rd_byte[6:0], 1'b0};
                        drive_n = ~i_rd_byte[7];
                        cnt_n   = 4'd1;
                    end else begin
                        state_n = ST_WRITE;
                        drive_n = 1'b0;
                    end
                end
                ST_WRITE: if (scl_rise) begin
                    shreg_n = byte_in;
                    cnt_n   = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n      = 4'd0;
                        wr_byte_n  = byte_in;
                        wr_valid_n = 1'b1;
                        state_n    = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: if (scl_fall) begin
                    drive_n = ~drive;
                    if (drive) begin
                        state_n = ST_WRITE;
                    end
                end
                // cnt counts bits already on the wire
                ST_READ: if (scl_fall) begin
                    if (cnt == 4'd8) begin
                        drive_n = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = ST_READ_ACK;
                    end else begin
                        drive_n = ~tx[7];
                        tx_n    = {tx[6:0], 1'b0};
                        cnt_n   = cnt + 4'd1;
                    end
                end
                // cnt==9 marks an ACK seen, reload at next fall
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_in == NACK) begin
                            nack_n  = 1'b1;
                            state_n = ST_IGNORE;
                        end else begin
                            rd_req_n = 1'b1;
                            cnt_n    = 4'd9;
                        end
                    end else if (scl_fall && cnt == 4'd9) begin
                        state_n = ST_READ;
                        tx_n    = {i_rd_byte[6:0], 1'b0};
                        drive_n = ~i_rd_byte[7];
                        cnt_n   = 4'd1;
                    end
                end
                default: drive_n = 1'b0;
            endcase
        end
    end

endmodule
